nibble_serial_adder: RTL and testbench

//  Multi-cycle wide adder/subtractor built around a single 4-bit ripple-carry add slice.
//  - Processes WIDTH = 4*NIBBLES bits one nibble per clock, LSB nibble first.
//  - Keeps the carry in a register between nibbles.
//  - Trades latency for area where a full-width adder is not justified.
//  - Front end is a start/done handshake so a host FSM can sequence repeated operations.
//

---
 rtl/nibble_serial_adder.sv | 121 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit ripple slice, LSB nibble first,
// with the carry held in a register between nibbles and a start/done handshake.
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int WIDTH = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CNT_W+1:0] nib_lsb;
    logic [3:0]       nib_a, nib_b, slice_s;
    logic             slice_c, slice_c3;

    assign nib_lsb = {cnt_q, 2'b00};
    assign nib_a   = opa_q[nib_lsb +: 4];
    assign nib_b   = opb_q[nib_lsb +: 4];

    // Ripple chain; the carry entering bit 3 is kept for signed overflow on the MSB nibble.
    always_comb begin
        slice_c  = carry_q;
        slice_c3 = 1'b0;
        slice_s  = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) slice_c3 = slice_c;
            slice_s[i] = nib_a[i] ^ nib_b[i] ^ slice_c;
            slice_c    = (nib_a[i] & nib_b[i]) | (slice_c & (nib_a[i] ^ nib_b[i]));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[nib_lsb +: 4] = slice_s;
                carry_d             = slice_c;
                cnt_d               = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cout_d  = slice_c;
                    ovf_d   = slice_c3 ^ slice_c;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4): hand-computed sums, latency and handshake.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one op, scramble inputs while it runs, and check latency, busy width and result.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tcin, input logic tsub, input logic [15:0] esum,
                          input logic ecout, input logic eovf, input logic pulse_in_done);
        int n;
        int busy_cnt;
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            a = 16'hA5C3 ^ 16'(n * 16'h1111); b = ~a; cin = ~cin; sub = ~sub;
            tick();
            n++;
        end
        chk({tag, " latency"}, n, 4);
        chk({tag, " busy_cycles"}, busy_cnt, 4);
        chk({tag, " sum"}, sum, esum);
        chk({tag, " cout"}, cout, ecout);
        chk({tag, " ovf"}, ovf, eovf);
        start = pulse_in_done;
        tick();
        start = 1'b0;
        chk({tag, " done_single"}, done, 0);
        tick();
        chk({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        int dcnt;
        int first_done;
        int second_done;
        int n;
        logic held_ok;

        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst sum", sum, 0);
        chk("rst cout", cout, 0);
        chk("rst ovf", ovf, 0);
        rst = 1'b0;
        tick();

        run_op("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("ripple_b1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("sub_5m7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_7m5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_op("add_cin", 16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0, 1'b1);

        // sum and flags must hold while idle, even with inputs wiggling
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 16'(i * 16'h0F0F); b = 16'(i * 16'h3333);
            tick();
            if (sum !== 16'hBE02 || busy !== 1'b0 || done !== 1'b0) held_ok = 1'b0;
        end
        chk("hold_10", held_ok, 1);

        // start held high: accepts at E0, E6, E12 -> done after E4, E10
        a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        dcnt = 0; first_done = -1; second_done = -1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (done) begin
                dcnt++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        chk("held_start done_count", dcnt, 2);
        chk("held_start first_done", first_done, 4);
        chk("held_start spacing", second_done - first_done, 6);
        chk("held_start sum", sum, 16'h0303);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("held_start drain", done, 1);
        tick();
        tick();

        // reset in the second RUN cycle aborts without a done pulse
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sum", sum, 0);
        chk("abort cout", cout, 0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) dcnt++;
        end
        chk("abort no_done", dcnt, 0);
        run_op("after_abort", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
